// File: rtl/fifo_reader.sv
// fifo_reader: pops a one-cycle-latency FIFO into a 2-entry output buffer served over valid/ready
module fifo_reader #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             RESET_L,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} st_t;
  st_t st_q, st_d;
  logic [1:0] occ_q, occ_d;
  logic inflight_q, busy_q, busy_d, pop;
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] fill;
  assign pop = out_valid && out_ready;
  assign fill = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign fifo_rd = (st_q == RUN) && !fifo_empty && (fill < 3'd2);
  assign out_valid = occ_q != 2'd0;
  assign out_data = head_q;
  assign busy = busy_q;
  assign word_cnt = cnt_q;
  always_comb begin
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pop};
    busy_d = (occ_d != 2'd0) || fifo_rd;
    // the capture lands at the head only if the head slot is free after this edge's pop
    head_d = (inflight_q && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) ? fifo_data :
             (pop && occ_q == 2'd2) ? tail_q : head_q;
    tail_d = (inflight_q && (occ_q == 2'd2 || (occ_q == 2'd1 && !pop))) ? fifo_data : tail_q;
    st_d = (st_q == IDLE) ? (enable ? RUN : IDLE) :
           (st_q == RUN)  ? (enable ? RUN : DRAIN) :
           enable ? RUN : (occ_q == 2'd0 && !inflight_q) ? IDLE : DRAIN;
  end
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      st_q       <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
    end else begin
      st_q       <= st_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd;
      busy_q     <= busy_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed and table-driven checks of fifo_reader against a behavioural FIFO
module tb_fifo_reader;
  logic clk = 1'b0, RESET_L = 1'b0, enable = 1'b0, out_ready = 1'b0;
  logic fifo_empty, fifo_rd, out_valid, busy;
  logic [5:0] fifo_data = '0, out_data;
  logic [7:0] word_cnt;
  logic [5:0] mem [0:1023];
  logic [5:0] rx [0:1023];
  int wp = 0, rp = 0, rx_n = 0, rd_n = 0, bad_rd = 0;
  logic seen255 = 1'b0;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic en; logic rdy; logic rd; logic vld; logic [5:0] dat; logic bsy; logic [7:0] cnt;
  } vec_t;
  vec_t tbl [8];

  fifo_reader #(.WIDTH(6), .CNT_W(8)) dut (
    .clk(clk), .RESET_L(RESET_L), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rp == wp);
  always @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      rp <= wp;
      fifo_data <= '0;
    end else if (fifo_rd) begin
      fifo_data <= mem[rp[9:0]];
      rp <= rp + 1;
    end
  end

  always @(negedge clk) begin
    if (RESET_L) begin
      if (fifo_rd) rd_n <= rd_n + 1;
      if (fifo_rd && fifo_empty) bad_rd <= bad_rd + 1;
      if (out_valid && out_ready) begin
        rx[rx_n[9:0]] <= out_data;
        rx_n <= rx_n + 1;
      end
      if (word_cnt == 8'd255) seen255 <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d);
    mem[wp[9:0]] = 6'(d);
    wp++;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    out_ready = 1'b0;
    RESET_L = 1'b0;
    tick(2);
    RESET_L = 1'b1;
  endtask

  task automatic wait_rx(input int target, input int limit, input string name);
    for (int i = 0; i < limit && rx_n < target; i++) tick(1);
    check(name, int'(rx_n >= target), 1);
  endtask

  initial begin
    int brd, brx, bad;
    tbl[0] = {1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 8'd0};
    tbl[1] = {1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 8'd0};
    tbl[2] = {1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 8'd0};
    tbl[3] = {1'b1, 1'b1, 1'b1, 1'b1, 6'd36, 1'b1, 8'd0};
    tbl[4] = {1'b1, 1'b1, 1'b1, 1'b1, 6'd54, 1'b1, 8'd1};
    tbl[5] = {1'b1, 1'b1, 1'b0, 1'b1, 6'd20, 1'b1, 8'd2};
    tbl[6] = {1'b1, 1'b1, 1'b0, 1'b1, 6'd48, 1'b1, 8'd3};
    tbl[7] = {1'b1, 1'b1, 1'b0, 1'b0, 6'd48, 1'b0, 8'd4};
    // reset state
    tick(2);
    check("rst.fifo_rd", int'(fifo_rd), 0);
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.out_data", int'(out_data), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.word_cnt", int'(word_cnt), 0);
    // single word
    do_reset();
    push(6'b010010);
    brd = rd_n; brx = rx_n;
    enable = 1'b1; out_ready = 1'b1;
    tick(8);
    check("single.reads", rd_n - brd, 1);
    check("single.words", rx_n - brx, 1);
    check("single.data", int'(rx[brx]), 18);
    check("single.word_cnt", int'(word_cnt), 1);
    check("single.busy", int'(busy), 0);
    // burst, cycle by cycle
    do_reset();
    push(6'b100100); push(6'b110110); push(6'b010100); push(6'b110000);
    for (int i = 0; i < 8; i++) begin
      enable = tbl[i].en;
      out_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("burst[%0d].fifo_rd", i), int'(fifo_rd), int'(tbl[i].rd));
      check($sformatf("burst[%0d].out_valid", i), int'(out_valid), int'(tbl[i].vld));
      check($sformatf("burst[%0d].out_data", i), int'(out_data), int'(tbl[i].dat));
      check($sformatf("burst[%0d].busy", i), int'(busy), int'(tbl[i].bsy));
      check($sformatf("burst[%0d].word_cnt", i), int'(word_cnt), int'(tbl[i].cnt));
      @(posedge clk);
      #1;
    end
    // backpressure
    do_reset();
    for (int i = 1; i <= 8; i++) push(i);
    brd = rd_n; brx = rx_n;
    enable = 1'b1; out_ready = 1'b0;
    tick(10);
    check("bp.reads_held", rd_n - brd, 2);
    check("bp.fifo_rd", int'(fifo_rd), 0);
    check("bp.out_data", int'(out_data), 1);
    check("bp.out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    wait_rx(brx + 8, 60, "bp.timeout");
    tick(3);
    check("bp.words", rx_n - brx, 8);
    check("bp.reads", rd_n - brd, 8);
    for (int i = 0; i < 8; i++) check($sformatf("bp.data[%0d]", i), int'(rx[brx + i]), i + 1);
    // disable mid-stream with inflight=1, occ=1
    do_reset();
    push(5); push(6); push(7); push(8);
    brd = rd_n; brx = rx_n;
    enable = 1'b1; out_ready = 1'b0;
    tick(3);
    check("dis.busy", int'(busy), 1);
    check("dis.reads_pre", rd_n - brd, 2);
    enable = 1'b0;
    tick(1);
    out_ready = 1'b1;
    tick(6);
    check("dis.reads_post", rd_n - brd, 2);
    check("dis.words", rx_n - brx, 2);
    check("dis.data0", int'(rx[brx]), 5);
    check("dis.data1", int'(rx[brx + 1]), 6);
    check("dis.idle", int'(dut.st_q), 0);
    check("dis.busy_end", int'(busy), 0);
    enable = 1'b1;
    wait_rx(brx + 4, 30, "dis.resume_timeout");
    check("dis.data2", int'(rx[brx + 2]), 7);
    check("dis.data3", int'(rx[brx + 3]), 8);
    check("dis.reads_total", rd_n - brd, 4);
    // asynchronous reset with occ=2
    out_ready = 1'b0;
    for (int i = 11; i <= 18; i++) push(i);
    tick(6);
    check("rmid.pre_valid", int'(out_valid), 1);
    check("rmid.pre_cnt", int'(word_cnt), 4);
    check("rmid.pre_occ", int'(dut.occ_q), 2);
    #2;
    RESET_L = 1'b0;
    #1;
    check("rmid.out_valid", int'(out_valid), 0);
    check("rmid.out_data", int'(out_data), 0);
    check("rmid.word_cnt", int'(word_cnt), 0);
    check("rmid.fifo_rd", int'(fifo_rd), 0);
    check("rmid.busy", int'(busy), 0);
    tick(1);
    RESET_L = 1'b1;
    push(33); push(34);
    brx = rx_n;
    enable = 1'b1; out_ready = 1'b1;
    wait_rx(brx + 2, 30, "rmid.restart_timeout");
    tick(3);
    check("rmid.words", rx_n - brx, 2);
    check("rmid.data0", int'(rx[brx]), 33);
    check("rmid.data1", int'(rx[brx + 1]), 34);
    check("rmid.word_cnt_after", int'(word_cnt), 2);
    // counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) push(i % 64);
    brd = rd_n; brx = rx_n;
    enable = 1'b1; out_ready = 1'b1;
    wait_rx(brx + 256, 400, "wrap.timeout");
    tick(3);
    bad = 0;
    for (int i = 0; i < 256; i++) if (int'(rx[brx + i]) != i % 64) bad++;
    check("wrap.seq_mismatches", bad, 0);
    check("wrap.reads", rd_n - brd, 256);
    check("wrap.seen255", int'(seen255), 1);
    check("wrap.word_cnt", int'(word_cnt), 0);
    check("rd_while_empty", bad_rd, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
